// File: rtl/firebird7_in_gate1_hdspsr_trim_apply_ctrl.sv
// HDSPSR trim apply sequencer: picks the fuse or IJTAG override trim word, snapshots it,
// and loads every array in turn using a load/ack handshake with a bounded ack wait.
module firebird7_in_gate1_hdspsr_trim_apply_ctrl #(
   parameter int NUM_ARRAYS  = 4,
   parameter int ACK_TIMEOUT = 15,
   localparam int IDX_W      = (NUM_ARRAYS > 1) ? $clog2(NUM_ARRAYS) : 1
) (
   input  logic                  ijtag_tck,
   input  logic                  ijtag_reset,
   input  logic                  fuse_valid,
   input  logic [18:0]           fuse_trim,
   input  logic                  trim_ovrd_en,
   input  logic [18:0]           trim_ovrd,
   input  logic                  apply_req,
   input  logic [NUM_ARRAYS-1:0] array_ack,
   output logic [18:0]           trim_out,
   output logic [NUM_ARRAYS-1:0] array_load,
   output logic                  busy,
   output logic                  done,
   output logic                  trim_applied,
   output logic                  ack_err,
   output logic [IDX_W-1:0]      err_idx
);

   typedef struct packed {
      logic [2:0] wa;
      logic [1:0] ra;
      logic [1:0] wmce;
      logic [1:0] wpulse;
      logic       mce;
      logic       shutoff;
      logic       wa_disable;
      logic       stbyp;
      logic [3:0] rmce;
      logic [1:0] sbc;
   } trim_word_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_LOAD,
      ST_WAIT_ACK,
      ST_NEXT
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_ARRAYS - 1);
   localparam logic [7:0]       TIMER_LAST = 8'(ACK_TIMEOUT - 1);

   state_t           state;
   state_t           state_nxt;
   logic             pending;
   logic             fuse_seen;
   logic             ovrd_en_prev;
   logic [IDX_W-1:0] idx;
   logic [7:0]       timer;
   trim_word_t       trim_q;
   trim_word_t       eff_word;

   logic             trigger;
   logic             can_start;
   logic             start_sweep;
   logic             ack_hit;
   logic             timed_out;
   logic             last_array;

   // Trigger sources are all level/edge conditions evaluated every cycle, in any state.
   always_comb begin
      trigger    = (fuse_valid && !fuse_seen) || apply_req || (trim_ovrd_en != ovrd_en_prev);
      can_start  = trim_ovrd_en || fuse_valid;
      eff_word   = trim_ovrd_en ? trim_ovrd : fuse_trim;
      ack_hit    = array_ack[idx];
      timed_out  = !ack_hit && (timer == TIMER_LAST);
      last_array = (idx == LAST_IDX);
   end

   always_comb begin
      state_nxt   = state;
      start_sweep = 1'b0;
      case (state)
         ST_IDLE: begin
            if ((trigger || pending) && can_start) begin
               state_nxt   = ST_CAPTURE;
               start_sweep = 1'b1;
            end
         end
         ST_CAPTURE:  state_nxt = ST_LOAD;
         ST_LOAD:     state_nxt = ST_WAIT_ACK;
         ST_WAIT_ACK: begin
            if (ack_hit || timed_out) begin
               state_nxt = ST_NEXT;
            end
         end
         ST_NEXT:     state_nxt = last_array ? ST_IDLE : ST_LOAD;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   // Triggers that cannot start a sweep right now collapse into a single pending flag.
   always_ff @(posedge ijtag_tck) begin
      if (ijtag_reset) begin
         state        <= ST_IDLE;
         pending      <= 1'b0;
         fuse_seen    <= 1'b0;
         ovrd_en_prev <= 1'b0;
      end else begin
         state        <= state_nxt;
         ovrd_en_prev <= trim_ovrd_en;
         if (fuse_valid) begin
            fuse_seen <= 1'b1;
         end
         if (start_sweep) begin
            pending <= 1'b0;
         end else if (trigger) begin
            pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge ijtag_tck) begin
      if (ijtag_reset) begin
         trim_q       <= '0;
         idx          <= '0;
         timer        <= '0;
         ack_err      <= 1'b0;
         err_idx      <= '0;
         done         <= 1'b0;
         trim_applied <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_sweep) begin
                  trim_applied <= 1'b0;
               end
            end
            ST_CAPTURE: begin
               trim_q  <= eff_word;
               idx     <= '0;
               ack_err <= 1'b0;
               err_idx <= '0;
            end
            ST_LOAD: begin
               timer <= '0;
            end
            ST_WAIT_ACK: begin
               if (timed_out) begin
                  ack_err <= 1'b1;
                  if (!ack_err) begin
                     err_idx <= idx;
                  end
               end else if (!ack_hit) begin
                  timer <= timer + 8'd1;
               end
            end
            ST_NEXT: begin
               if (last_array) begin
                  done         <= 1'b1;
                  trim_applied <= 1'b1;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      array_load = '0;
      if (state == ST_LOAD) begin
         array_load[idx] = 1'b1;
      end
   end

   assign busy     = (state != ST_IDLE);
   assign trim_out = trim_q;

endmodule

// File: tb/tb_firebird7_in_gate1_hdspsr_trim_apply_ctrl.sv
// Self-checking bench for the HDSPSR trim apply sequencer: a behavioural array responder,
// an event log, and a schedule predictor built from per-array ack latencies.
module tb_firebird7_in_gate1_hdspsr_trim_apply_ctrl;

   localparam int N     = 4;
   localparam int TMO   = 15;
   localparam int IW    = 2;
   localparam int NEVER = -1;

   logic          clk = 1'b0;
   logic          rst;
   logic          fuse_valid;
   logic [18:0]   fuse_trim;
   logic          trim_ovrd_en;
   logic [18:0]   trim_ovrd;
   logic          apply_req;
   logic [N-1:0]  array_ack;
   logic [N-1:0]  resp_ack;
   logic [N-1:0]  spur_ack;
   logic [18:0]   trim_out;
   logic [N-1:0]  array_load;
   logic          busy;
   logic          done;
   logic          trim_applied;
   logic          ack_err;
   logic [IW-1:0] err_idx;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int bad_load = 0;
   int delay [N];
   int ack_cnt [N];

   int            load_cyc[$];
   int            load_idx[$];
   logic [18:0]   load_trim[$];
   int            done_cyc[$];
   logic          done_err[$];
   logic          done_applied[$];
   logic [IW-1:0] done_eidx[$];

   int exp_load [N];
   int exp_done;
   int exp_eidx;
   bit exp_err;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign array_ack = resp_ack | spur_ack;

   firebird7_in_gate1_hdspsr_trim_apply_ctrl #(.NUM_ARRAYS(N), .ACK_TIMEOUT(TMO)) dut (
      .ijtag_tck(clk),
      .ijtag_reset(rst),
      .fuse_valid(fuse_valid),
      .fuse_trim(fuse_trim),
      .trim_ovrd_en(trim_ovrd_en),
      .trim_ovrd(trim_ovrd),
      .apply_req(apply_req),
      .array_ack(array_ack),
      .trim_out(trim_out),
      .array_load(array_load),
      .busy(busy),
      .done(done),
      .trim_applied(trim_applied),
      .ack_err(ack_err),
      .err_idx(err_idx)
   );

   // Each array acks delay[i] cycles after it sees its load strobe, for one cycle.
   initial begin
      resp_ack = '0;
      for (int i = 0; i < N; i++) ack_cnt[i] = 0;
      forever begin
         @(negedge clk);
         resp_ack = '0;
         for (int i = 0; i < N; i++) begin
            if (ack_cnt[i] > 0) begin
               ack_cnt[i]--;
               if (ack_cnt[i] == 0) resp_ack[i] = 1'b1;
            end
            if (array_load[i] && delay[i] != NEVER) ack_cnt[i] = delay[i];
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (array_load != '0) begin
            if ($countones(array_load) != 1) bad_load++;
            for (int i = 0; i < N; i++) begin
               if (array_load[i]) begin
                  load_cyc.push_back(cyc);
                  load_idx.push_back(i);
                  load_trim.push_back(trim_out);
               end
            end
         end
         if (done) begin
            done_cyc.push_back(cyc);
            done_err.push_back(ack_err);
            done_eidx.push_back(err_idx);
            done_applied.push_back(trim_applied);
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog got=time limit reached exp=bench completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_log();
      load_cyc.delete();
      load_idx.delete();
      load_trim.delete();
      done_cyc.delete();
      done_err.delete();
      done_eidx.delete();
      done_applied.delete();
   endtask

   task automatic set_delays(input int d);
      for (int i = 0; i < N; i++) delay[i] = d;
   endtask

   task automatic wait_dones(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         tick();
         if (done_cyc.size() >= n) ok = 1'b1;
      end
   endtask

   // Expected schedule from ack latencies: an ack after d cycles costs 2+d, a miss costs 2+TMO.
   function automatic void predict(input int k);
      int l;
      l        = k + 2;
      exp_err  = 1'b0;
      exp_eidx = 0;
      for (int i = 0; i < N; i++) begin
         exp_load[i] = l;
         if (delay[i] >= 1 && delay[i] <= TMO) begin
            l += 2 + delay[i];
         end else begin
            if (!exp_err) exp_eidx = i;
            exp_err = 1'b1;
            l += 2 + TMO;
         end
      end
      exp_done = l;
   endfunction

   task automatic test_reset();
      rst = 1'b1; fuse_valid = 1'b0; fuse_trim = '0; trim_ovrd_en = 1'b0;
      trim_ovrd = '0; apply_req = 1'b0; spur_ack = '0;
      set_delays(1);
      tick(3);
      checks++;
      if (trim_out !== 19'h0 || array_load !== '0) begin
         errors++; $display("[TB] FAIL reset_data got trim=%05h load=%b exp trim=00000 load=0000", trim_out, array_load);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || trim_applied !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_status got busy=%b done=%b applied=%b exp 0 0 0", busy, done, trim_applied);
      end
      checks++;
      if (ack_err !== 1'b0 || err_idx !== '0) begin
         errors++; $display("[TB] FAIL reset_err got ack_err=%b err_idx=%0d exp 0 0", ack_err, err_idx);
      end
      rst = 1'b0;
      tick(5);
      checks++;
      if (busy !== 1'b0 || load_cyc.size() !== 0) begin
         errors++; $display("[TB] FAIL idle_no_trigger got busy=%b loads=%0d exp busy=0 loads=0", busy, load_cyc.size());
      end
   endtask

   task automatic test_fuse_path();
      int k; bit ok;
      clear_log(); set_delays(1);
      fuse_trim = 19'h5A5A5; fuse_valid = 1'b1; k = cyc;
      tick();
      checks++;
      if (busy !== 1'b1 || trim_applied !== 1'b0) begin
         errors++; $display("[TB] FAIL fuse_capture_busy got busy=%b applied=%b exp 1 0", busy, trim_applied);
      end
      wait_dones(1, 60, ok); tick(5); predict(k);
      checks++;
      if (!ok || load_cyc.size() !== N) begin
         errors++; $display("[TB] FAIL fuse_load_count got=%0d exp=%0d", load_cyc.size(), N);
      end
      for (int i = 0; i < N && i < load_cyc.size(); i++) begin
         checks++;
         if (load_cyc[i] !== exp_load[i] || load_idx[i] !== i || load_trim[i] !== 19'h5A5A5) begin
            errors++; $display("[TB] FAIL fuse_load%0d got cyc=%0d idx=%0d trim=%05h exp cyc=%0d idx=%0d trim=5a5a5",
                               i, load_cyc[i], load_idx[i], load_trim[i], exp_load[i], i);
         end
      end
      checks++;
      if (done_cyc.size() !== 1 || done_cyc[0] !== exp_done || done_err[0] !== 1'b0 || done_applied[0] !== 1'b1) begin
         errors++; $display("[TB] FAIL fuse_done got n=%0d cyc=%0d exp n=1 cyc=%0d err=0 applied=1",
                            done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, exp_done);
      end
      checks++;
      if (trim_out !== 19'h5A5A5 || trim_applied !== 1'b1 || busy !== 1'b0 || ack_err !== 1'b0) begin
         errors++; $display("[TB] FAIL fuse_after got trim=%05h applied=%b busy=%b err=%b exp 5a5a5 1 0 0",
                            trim_out, trim_applied, busy, ack_err);
      end
   endtask

   task automatic test_override();
      int k; bit ok; logic [18:0] w;
      clear_log(); set_delays(1);
      fuse_valid = 1'b0; tick(2);
      trim_ovrd = 19'h7FFFF; trim_ovrd_en = 1'b1; k = cyc;
      wait_dones(1, 60, ok); tick(3); predict(k);
      checks++;
      if (!ok || load_cyc.size() !== N || done_cyc[0] !== exp_done) begin
         errors++; $display("[TB] FAIL ovrd_sweep got loads=%0d done=%0d exp loads=%0d done=%0d",
                            load_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, N, exp_done);
      end
      for (int i = 0; i < N && i < load_cyc.size(); i++) begin
         checks++;
         if (load_cyc[i] !== exp_load[i] || load_trim[i] !== 19'h7FFFF) begin
            errors++; $display("[TB] FAIL ovrd_load%0d got cyc=%0d trim=%05h exp cyc=%0d trim=7ffff",
                               i, load_cyc[i], load_trim[i], exp_load[i]);
         end
      end
      clear_log();
      trim_ovrd_en = 1'b0;
      tick(30);
      checks++;
      if (load_cyc.size() !== 0 || busy !== 1'b0) begin
         errors++; $display("[TB] FAIL ovrd_pending_held got loads=%0d busy=%b exp loads=0 busy=0", load_cyc.size(), busy);
      end
      w = 19'($urandom());
      fuse_trim = w; fuse_valid = 1'b1; k = cyc;
      wait_dones(1, 60, ok); tick(3); predict(k);
      checks++;
      if (!ok || load_cyc.size() !== N || done_cyc[0] !== exp_done) begin
         errors++; $display("[TB] FAIL pending_release got loads=%0d done=%0d exp loads=%0d done=%0d",
                            load_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, N, exp_done);
      end
      for (int i = 0; i < N && i < load_cyc.size(); i++) begin
         checks++;
         if (load_cyc[i] !== exp_load[i] || load_trim[i] !== w) begin
            errors++; $display("[TB] FAIL pending_load%0d got cyc=%0d trim=%05h exp cyc=%0d trim=%05h",
                               i, load_cyc[i], load_trim[i], exp_load[i], w);
         end
      end
   endtask

   task automatic test_timeout();
      int k; bit ok;
      // Sweep 1: array 2 silent; sweep 2: ack on the last allowed cycle; sweep 3: arrays 1 and 2 silent.
      for (int s = 0; s < 3; s++) begin
         clear_log(); set_delays(1);
         if (s == 0) delay[2] = NEVER;
         if (s == 1) delay[2] = TMO;
         if (s == 2) begin delay[1] = NEVER; delay[2] = NEVER; end
         apply_req = 1'b1; k = cyc; tick(); apply_req = 1'b0;
         wait_dones(1, 120, ok); tick(3); predict(k);
         checks++;
         if (!ok || load_cyc.size() !== N) begin
            errors++; $display("[TB] FAIL tmo%0d_load_count got=%0d exp=%0d", s, load_cyc.size(), N);
         end
         for (int i = 0; i < N && i < load_cyc.size(); i++) begin
            checks++;
            if (load_cyc[i] !== exp_load[i] || load_idx[i] !== i) begin
               errors++; $display("[TB] FAIL tmo%0d_load%0d got cyc=%0d idx=%0d exp cyc=%0d idx=%0d",
                                  s, i, load_cyc[i], load_idx[i], exp_load[i], i);
            end
         end
         if (s < 2 && load_cyc.size() == N) begin
            checks++;
            if (load_cyc[3] - load_cyc[2] - 2 !== TMO) begin
               errors++; $display("[TB] FAIL tmo%0d_wait_cycles got=%0d exp=%0d", s, load_cyc[3] - load_cyc[2] - 2, TMO);
            end
         end
         checks++;
         if (done_cyc.size() !== 1 || done_cyc[0] !== exp_done || done_err[0] !== exp_err || done_eidx[0] !== IW'(exp_eidx)) begin
            errors++; $display("[TB] FAIL tmo%0d_done got n=%0d cyc=%0d err=%b idx=%0d exp n=1 cyc=%0d err=%b idx=%0d",
                               s, done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1,
                               (done_cyc.size() > 0) ? done_err[0] : 1'bx, (done_cyc.size() > 0) ? done_eidx[0] : 'x,
                               exp_done, exp_err, exp_eidx);
         end
         checks++;
         if (ack_err !== exp_err || err_idx !== IW'(exp_eidx)) begin
            errors++; $display("[TB] FAIL tmo%0d_held got err=%b idx=%0d exp err=%b idx=%0d", s, ack_err, err_idx, exp_err, exp_eidx);
         end
      end
   endtask

   task automatic test_back_to_back();
      int k; bit ok; logic [18:0] w1, w2;
      clear_log(); set_delays(1);
      w1 = 19'($urandom()); w2 = ~w1;
      fuse_trim = w1;
      apply_req = 1'b1; k = cyc; tick(); apply_req = 1'b0;
      tick(2);
      checks++;
      if (busy !== 1'b1 || trim_applied !== 1'b0) begin
         errors++; $display("[TB] FAIL b2b_busy got busy=%b applied=%b exp 1 0", busy, trim_applied);
      end
      apply_req = 1'b1; tick(); apply_req = 1'b0; fuse_trim = w2; tick();
      apply_req = 1'b1; tick(); apply_req = 1'b0; tick();
      apply_req = 1'b1; tick(); apply_req = 1'b0;
      trim_ovrd_en = 1'b1; tick(); trim_ovrd_en = 1'b0; tick();
      wait_dones(2, 100, ok); tick(20);
      checks++;
      if (!ok || done_cyc.size() !== 2 || load_cyc.size() !== 2 * N) begin
         errors++; $display("[TB] FAIL b2b_sweep_count got dones=%0d loads=%0d exp dones=2 loads=%0d",
                            done_cyc.size(), load_cyc.size(), 2 * N);
      end
      if (done_cyc.size() == 2 && load_cyc.size() == 2 * N) begin
         predict(k);
         for (int i = 0; i < N; i++) begin
            checks++;
            if (load_cyc[i] !== exp_load[i] || load_trim[i] !== w1) begin
               errors++; $display("[TB] FAIL b2b_first%0d got cyc=%0d trim=%05h exp cyc=%0d trim=%05h",
                                  i, load_cyc[i], load_trim[i], exp_load[i], w1);
            end
         end
         checks++;
         if (done_cyc[0] !== exp_done) begin
            errors++; $display("[TB] FAIL b2b_first_done got=%0d exp=%0d", done_cyc[0], exp_done);
         end
         // The follow-on sweep is accepted on the single IDLE cycle that carries done.
         predict(exp_done);
         for (int i = 0; i < N; i++) begin
            checks++;
            if (load_cyc[N + i] !== exp_load[i] || load_idx[N + i] !== i || load_trim[N + i] !== w2) begin
               errors++; $display("[TB] FAIL b2b_second%0d got cyc=%0d idx=%0d trim=%05h exp cyc=%0d idx=%0d trim=%05h",
                                  i, load_cyc[N + i], load_idx[N + i], load_trim[N + i], exp_load[i], i, w2);
            end
         end
         checks++;
         if (done_cyc[1] !== exp_done) begin
            errors++; $display("[TB] FAIL b2b_second_done got=%0d exp=%0d", done_cyc[1], exp_done);
         end
      end
   endtask

   task automatic test_reset_mid();
      int k; bit ok;
      clear_log(); set_delays(1); delay[1] = NEVER;
      fuse_trim = 19'h3C3C3; fuse_valid = 1'b1;
      apply_req = 1'b1; k = cyc; tick(); apply_req = 1'b0;
      tick(k + 8 - cyc);
      checks++;
      if (busy !== 1'b1 || trim_out !== 19'h3C3C3) begin
         errors++; $display("[TB] FAIL rstmid_pre got busy=%b trim=%05h exp 1 3c3c3", busy, trim_out);
      end
      rst = 1'b1; tick();
      checks++;
      if (trim_out !== 19'h0 || array_load !== '0 || busy !== 1'b0) begin
         errors++; $display("[TB] FAIL rstmid_data got trim=%05h load=%b busy=%b exp 00000 0000 0", trim_out, array_load, busy);
      end
      checks++;
      if (done !== 1'b0 || trim_applied !== 1'b0 || ack_err !== 1'b0 || err_idx !== '0) begin
         errors++; $display("[TB] FAIL rstmid_status got done=%b applied=%b err=%b idx=%0d exp 0 0 0 0",
                            done, trim_applied, ack_err, err_idx);
      end
      rst = 1'b0; set_delays(1); clear_log(); k = cyc;
      wait_dones(1, 60, ok); tick(3); predict(k);
      checks++;
      if (!ok || load_cyc.size() !== N || done_cyc[0] !== exp_done) begin
         errors++; $display("[TB] FAIL rstmid_resweep got loads=%0d done=%0d exp loads=%0d done=%0d",
                            load_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, N, exp_done);
      end
      for (int i = 0; i < N && i < load_cyc.size(); i++) begin
         checks++;
         if (load_cyc[i] !== exp_load[i] || load_idx[i] !== i || load_trim[i] !== 19'h3C3C3) begin
            errors++; $display("[TB] FAIL rstmid_load%0d got cyc=%0d idx=%0d trim=%05h exp cyc=%0d idx=%0d trim=3c3c3",
                               i, load_cyc[i], load_idx[i], load_trim[i], exp_load[i], i);
         end
      end
   endtask

   task automatic test_spurious_ack();
      int k; int r;
      clear_log(); set_delays(1); delay[0] = 3; delay[1] = 3;
      apply_req = 1'b1; k = cyc; tick(); apply_req = 1'b0;
      for (int c = 0; c < 30; c++) begin
         r = cyc - k;
         spur_ack = '0;
         if (r >= 2 && r <= 4) spur_ack[3] = 1'b1;
         if (r == 7) spur_ack[1] = 1'b1;
         tick();
      end
      spur_ack = '0;
      predict(k);
      checks++;
      if (load_cyc.size() !== N || done_cyc.size() !== 1) begin
         errors++; $display("[TB] FAIL spur_counts got loads=%0d dones=%0d exp loads=%0d dones=1", load_cyc.size(), done_cyc.size(), N);
      end
      for (int i = 0; i < N && i < load_cyc.size(); i++) begin
         checks++;
         if (load_cyc[i] !== exp_load[i] || load_idx[i] !== i) begin
            errors++; $display("[TB] FAIL spur_load%0d got cyc=%0d idx=%0d exp cyc=%0d idx=%0d",
                               i, load_cyc[i], load_idx[i], exp_load[i], i);
         end
      end
      checks++;
      if (done_cyc.size() < 1 || done_cyc[0] !== exp_done || done_err[0] !== 1'b0) begin
         errors++; $display("[TB] FAIL spur_done got cyc=%0d exp cyc=%0d err=0", (done_cyc.size() > 0) ? done_cyc[0] : -1, exp_done);
      end
   endtask

   task automatic test_random();
      int k; bit ok; logic [18:0] w;
      for (int s = 0; s < 8; s++) begin
         clear_log();
         // Latencies beyond TMO land after the array has been skipped and must be ignored.
         for (int i = 0; i < N; i++) delay[i] = int'($urandom_range(1, TMO + 3));
         fuse_trim = 19'($urandom());
         trim_ovrd = 19'($urandom());
         if ($urandom_range(0, 1) == 1) trim_ovrd_en = ~trim_ovrd_en;
         else apply_req = 1'b1;
         w = trim_ovrd_en ? trim_ovrd : fuse_trim;
         k = cyc; tick(); apply_req = 1'b0;
         wait_dones(1, 200, ok); tick(4); predict(k);
         checks++;
         if (!ok || load_cyc.size() !== N || done_cyc.size() !== 1) begin
            errors++; $display("[TB] FAIL rnd%0d_counts got loads=%0d dones=%0d exp loads=%0d dones=1", s, load_cyc.size(), done_cyc.size(), N);
         end
         for (int i = 0; i < N && i < load_cyc.size(); i++) begin
            checks++;
            if (load_cyc[i] !== exp_load[i] || load_idx[i] !== i || load_trim[i] !== w) begin
               errors++; $display("[TB] FAIL rnd%0d_load%0d got cyc=%0d idx=%0d trim=%05h exp cyc=%0d idx=%0d trim=%05h",
                                  s, i, load_cyc[i], load_idx[i], load_trim[i], exp_load[i], i, w);
            end
         end
         checks++;
         if (done_cyc.size() < 1 || done_cyc[0] !== exp_done || done_err[0] !== exp_err || done_eidx[0] !== IW'(exp_eidx)) begin
            errors++; $display("[TB] FAIL rnd%0d_done got cyc=%0d err=%b idx=%0d exp cyc=%0d err=%b idx=%0d",
                               s, (done_cyc.size() > 0) ? done_cyc[0] : -1, (done_cyc.size() > 0) ? done_err[0] : 1'bx,
                               (done_cyc.size() > 0) ? done_eidx[0] : 'x, exp_done, exp_err, exp_eidx);
         end
      end
      checks++;
      if (bad_load !== 0) begin
         errors++; $display("[TB] FAIL load_onehot got violations=%0d exp=0", bad_load);
      end
   endtask

   initial begin
      spur_ack = '0;
      test_reset();
      test_fuse_path();
      test_override();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_spurious_ack();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
